// File: rtl/regbank_write_arbiter_if.sv
// ============================================================================
// Module      : regbank_write_arbiter_if
// Description : Requester handshakes and register-bank write port of the
//               register-bank write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regbank_write_arbiter_if;
    logic        req0;
    logic [4:0]  addr0;
    logic [63:0] data0;
    logic        gnt0;

    logic        req1;
    logic [4:0]  addr1;
    logic [63:0] data1;
    logic        gnt1;

    logic        write;
    logic [4:0]  write_register;
    logic [63:0] write_data;

    modport master (
        output req0, addr0, data0, req1, addr1, data1,
        input  gnt0, gnt1, write, write_register, write_data
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1,
        output gnt0, gnt1, write, write_register, write_data
    );
endinterface

`default_nettype wire

// File: rtl/regbank_write_arbiter.sv
// ============================================================================
// Module      : regbank_write_arbiter
// Description : Round-robin arbiter for two register-bank writers with a
//               sequential whole-bank clear that takes priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_write_arbiter #(
    parameter int          NREGS       = 32,
    parameter logic [63:0] CLEAR_VALUE = 64'd0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    regbank_write_arbiter_if.slave bus,
    input  wire logic              clear_start,
    output logic                   busy,
    output logic                   clear_done
);

    localparam logic [5:0] c_nregs = 6'(NREGS);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_write;
    logic        w_write_nxt;
    logic [4:0]  r_wreg;
    logic [4:0]  w_wreg_nxt;
    logic [63:0] r_wdata;
    logic [63:0] w_wdata_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic [5:0]  r_count;
    logic [5:0]  w_count_nxt;
    // 1 when requester 1 won the most recent transfer
    logic        r_last1;
    logic        w_last1_nxt;

    logic        w_arb_en;
    logic        w_gnt0;
    logic        w_gnt1;

    // Grants are suppressed in reset, during a clear and on a clear-start cycle.
    assign w_arb_en = rst_n && (r_state == ARB) && !clear_start;
    assign w_gnt0   = w_arb_en && bus.req0 && (!bus.req1 || r_last1);
    assign w_gnt1   = w_arb_en && bus.req1 && (!bus.req0 || !r_last1);

    assign bus.gnt0           = w_gnt0;
    assign bus.gnt1           = w_gnt1;
    assign bus.write          = r_write;
    assign bus.write_register = r_wreg;
    assign bus.write_data     = r_wdata;
    assign busy               = rst_n && (r_state == CLEAR);
    assign clear_done         = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_write_nxt = 1'b0;
        w_wreg_nxt  = r_wreg;
        w_wdata_nxt = r_wdata;
        w_done_nxt  = 1'b0;
        w_count_nxt = r_count;
        w_last1_nxt = r_last1;
        case (r_state)
            ARB: begin
                if (clear_start) begin
                    w_state_nxt = CLEAR;
                    w_write_nxt = 1'b1;
                    w_wreg_nxt  = 5'd0;
                    w_wdata_nxt = CLEAR_VALUE;
                    w_count_nxt = 6'd1;
                end else if (w_gnt0) begin
                    w_write_nxt = 1'b1;
                    w_wreg_nxt  = bus.addr0;
                    w_wdata_nxt = bus.data0;
                    w_last1_nxt = 1'b0;
                end else if (w_gnt1) begin
                    w_write_nxt = 1'b1;
                    w_wreg_nxt  = bus.addr1;
                    w_wdata_nxt = bus.data1;
                    w_last1_nxt = 1'b1;
                end
            end
            CLEAR: begin
                if (r_count == c_nregs) begin
                    w_state_nxt = ARB;
                    w_done_nxt  = 1'b1;
                    w_count_nxt = 6'd0;
                end else begin
                    w_write_nxt = 1'b1;
                    w_wreg_nxt  = r_count[4:0];
                    w_wdata_nxt = CLEAR_VALUE;
                    w_count_nxt = r_count + 6'd1;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB;
            r_write <= 1'b0;
            r_wreg  <= 5'd0;
            r_wdata <= 64'd0;
            r_done  <= 1'b0;
            r_count <= 6'd0;
            r_last1 <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_write <= w_write_nxt;
            r_wreg  <= w_wreg_nxt;
            r_wdata <= w_wdata_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
            r_last1 <= w_last1_nxt;
        end
    end

endmodule

`default_nettype wire

// File: doc/regbank_write_arbiter.md
REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

Interface
REQ-001 The block SHALL have one parameter: NREGS, default 32, number of registers swept by a clear (addresses 0..NREGS-1, NREGS<=32).
REQ-002 The block SHALL have one parameter: CLEAR_VALUE, default 64'd0, data written to every register during a clear.
REQ-003 The block SHALL use one clock and a synchronous active-low reset, with these ports:
- clk  input  1  clock, all state updates on its rising edge
- rst_n  input  1  synchronous active-low reset
REQ-004 The block SHALL have these requester-0 ports:
- req0  input  1  requester 0 write request
- addr0  input  5  requester 0 destination register
- data0  input  64  requester 0 write data
- gnt0  output  1  combinational grant to requester 0
REQ-005 The block SHALL have these requester-1 ports:
- req1  input  1  requester 1 write request
- addr1  input  5  requester 1 destination register
- data1  input  64  requester 1 write data
- gnt1  output  1  combinational grant to requester 1
REQ-006 The block SHALL have these clear-control ports:
- clear_start  input  1  one-cycle pulse starting a register-bank clear
- busy  output  1  high while a clear is in progress
- clear_done  output  1  one-cycle pulse when a clear completes
REQ-007 The block SHALL have these register-bank write-port ports, all registered:
- write  output  1  write enable to the register bank
- write_register  output  5  write address to the register bank
- write_data  output  64  write data to the register bank

Function
REQ-008 The block SHALL implement two states: ARB and CLEAR.
REQ-009 A transfer SHALL occur on a rising edge where reqX=1 and gntX=1.
REQ-010 A requester SHALL hold reqX, addrX and dataX stable until its transfer edge.
REQ-011 In ARB with clear_start=0, the block SHALL assert exactly one gnt when at least one req is high and no gnt otherwise.
REQ-012 When only one req is high, its gnt SHALL be asserted.
REQ-013 When both reqs are high, the block SHALL grant the requester that did not win the most recent transfer (round-robin).
REQ-014 The round-robin pointer SHALL update only on transfer edges.
REQ-015 On a transfer edge, the block SHALL load write=1, write_register=addrX and write_data=dataX, visible in the next cycle (latency 1).
REQ-016 On an edge in ARB with no transfer and no clear start, the block SHALL load write=0 and SHALL hold write_register and write_data.
REQ-017 Back-to-back transfers SHALL be supported: one write per cycle, 100% port utilisation.
REQ-018 Address 0 SHALL be written like any other address (no hardwired zero register).
REQ-019 In ARB, clear_start=1 SHALL force gnt0=gnt1=0 in that cycle, so clear takes priority over simultaneous requests.
REQ-020 On the edge where clear_start=1 is sampled in ARB, the block SHALL enter CLEAR and load write=1, write_register=0, write_data=CLEAR_VALUE, and the internal counter to 1.
REQ-021 On each edge in CLEAR while counter<NREGS, the block SHALL load write=1, write_register=counter, write_data=CLEAR_VALUE, and increment the counter.
REQ-022 The result of REQ-020 and REQ-021 SHALL be NREGS consecutive write cycles with addresses 0..NREGS-1.
REQ-023 On the edge where counter==NREGS in CLEAR, the block SHALL load write=0 and clear_done=1 and return to ARB.
REQ-024 In the cycle where clear_done=1, grants SHALL be allowed.
REQ-025 clear_done SHALL be high for exactly one cycle.
REQ-026 In CLEAR, the block SHALL hold gnt0=gnt1=0 and busy=1.
REQ-027 In CLEAR, clear_start SHALL be ignored (no restart, no extension).
REQ-028 Requests pending in CLEAR SHALL be held, not dropped, and arbitrated normally once back in ARB.
REQ-029 In ARB, busy SHALL be 0.

Reset
REQ-030 While rst_n=0 at a rising edge, the block SHALL load state=ARB, write=0, write_register=0, write_data=0, clear_done=0, counter=0, and the round-robin pointer so that requester 0 wins the first contended grant.
REQ-031 During reset, gnt0=gnt1=0 and busy=0.
REQ-032 Reset asserted mid-clear SHALL abort the clear with no clear_done pulse.

Verification
REQ-033 Single request: req0=1, addr0=5, data0=64'hAA for one edge -> gnt0=1 that cycle; next cycle write=1, write_register=5, write_data=64'hAA; following cycle write=0.
REQ-034 Contention: req0=req1=1 held for 4 edges after reset -> grants go 0,1,0,1; write_register alternates addr0/addr1 on 4 consecutive cycles.
REQ-035 Clear: clear_start pulse in ARB -> 32 consecutive cycles of write=1, write_register 0..31, write_data=0; busy=1 throughout; clear_done=1 the cycle after address 31; then busy=0.
REQ-036 Clear vs request: clear_start=1 with req1=1 in the same cycle -> gnt1=0; req1 held; gnt1=1 in the clear_done cycle; req1's data written the next cycle.
REQ-037 Reset mid-clear: rst_n=0 at sweep address 10 -> write=0, busy=0 next cycle, no clear_done; a new clear_start restarts at address 0.
